// File: rtl/rf_pkg.sv
// Shared register-file types and defaults, reused by decode and the hazard unit.
package rf_pkg;

  localparam int unsigned XLEN_DEF  = 64;
  localparam int unsigned NREGS_DEF = 32;

  // Ceiling log2 usable in constant expressions; returns at least 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

  localparam int unsigned AW_DEF = clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xdata_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NWRITE   = 2,
  parameter int unsigned AW       = clog2(NREGS),
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_rd,
  input  logic [NWRITE-1:0]    wr_en,
  input  logic [NWRITE*AW-1:0] wr_addr,
  output logic [NREGS-1:0]     busy_vec
);

  logic [NREGS-1:0] set_v;
  logic [NREGS-1:0] clr_v;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    for (int r = 0; r < NREGS; r++) begin
      set_v[r] = iss_en && (iss_rd == AW'(r));
      for (int k = 0; k < NWRITE; k++) begin
        if (wr_en[k] && (wr_addr[k*AW +: AW] == AW'(r))) clr_v[r] = 1'b1;
      end
    end
    if (ZERO_REG != 0) set_v[0] = 1'b0;
  end

  // A new producer issued alongside the old writeback keeps the register busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_vec <= '0;
    else        busy_vec <= (busy_vec & ~clr_v) | set_v;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and
// a pending-write scoreboard feeding the hazard unit.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NWRITE-1:0]             wr_en,
  input  logic [NWRITE*clog2(NREGS)-1:0] wr_addr,
  input  logic [NWRITE*XLEN-1:0]        wr_data,
  input  logic [NREAD*clog2(NREGS)-1:0] rd_addr,
  output logic [NREAD*XLEN-1:0]         rd_data,
  output logic [NREAD-1:0]              rd_busy,
  input  logic                          iss_en,
  input  logic [clog2(NREGS)-1:0]       iss_rd,
  output logic [NREGS-1:0]              busy_vec
);

  localparam int unsigned AW = clog2(NREGS);

  logic [XLEN-1:0] mem [NREGS];

  // Later ports overwrite earlier ones, so the youngest writer wins a conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else begin
      for (int k = 0; k < NWRITE; k++) begin
        if (wr_en[k] && !((ZERO_REG != 0) && (wr_addr[k*AW +: AW] == '0)))
          mem[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
      end
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .NWRITE   (NWRITE),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy_vec (busy_vec)
  );

  // Per-read-port lookup, bypass mux and busy masking.
  always_comb begin
    logic [AW-1:0] ra;
    logic          hit;
    rd_data = '0;
    rd_busy = '0;
    for (int j = 0; j < NREAD; j++) begin
      ra  = rd_addr[j*AW +: AW];
      hit = 1'b0;
      rd_data[j*XLEN +: XLEN] = mem[ra];
      for (int k = 0; k < NWRITE; k++) begin
        if (wr_en[k] && (wr_addr[k*AW +: AW] == ra)) begin
          hit = 1'b1;
          if (BYPASS != 0) rd_data[j*XLEN +: XLEN] = wr_data[k*XLEN +: XLEN];
        end
      end
      if (((ZERO_REG != 0) && (ra == '0)) || !reset) rd_data[j*XLEN +: XLEN] = '0;
      rd_busy[j] = busy_vec[ra] && !((BYPASS != 0) && hit);
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing instance and one non-bypassing
// instance driven by the same stimulus.
module tb_regfile_mp;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        wr_en;
  logic [2*AW-1:0]   wr_addr;
  logic [2*XLEN-1:0] wr_data;
  logic [2*AW-1:0]   rd_addr;
  logic              iss_en;
  logic [AW-1:0]     iss_rd;
  logic [2*XLEN-1:0] rd_data, rd_data_nb;
  logic [1:0]        rd_busy, rd_busy_nb;
  logic [NREGS-1:0]  busy_vec, busy_vec_nb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(2), .NWRITE(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_en(iss_en), .iss_rd(iss_rd), .busy_vec(busy_vec));

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(2), .NWRITE(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .iss_en(iss_en), .iss_rd(iss_rd), .busy_vec(busy_vec_nb));

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    iss_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; iss_en = 1'b0; iss_rd = '0;
    #1;
    chk("rst_rd0",  rd_data[63:0], 64'h0);
    chk("rst_busy", 64'(busy_vec), 64'h0);
    @(negedge clk); reset = 1'b1;

    // 1: reset mid-sequence
    @(negedge clk);
    wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[63:0] = 64'hDEAD; rd_addr[4:0] = 5'd5;
    #1 chk("t1_bypass", rd_data[63:0], 64'hDEAD);
    edge_step(); idle();
    chk("t1_stored", rd_data[63:0], 64'hDEAD);
    #2 reset = 1'b0;
    #1 chk("t1_rst_rd", rd_data[63:0], 64'h0);
    chk("t1_rst_rdbusy", 64'(rd_busy), 64'h0);
    @(negedge clk); reset = 1'b1;
    #1 chk("t1_after_rel", rd_data[63:0], 64'h0);

    // 2: write latency, non-bypassing instance
    @(negedge clk);
    wr_en = 2'b01; wr_addr[4:0] = 5'd7; wr_data[63:0] = 64'h1234; rd_addr[4:0] = 5'd7;
    #1 chk("t2_nb_before", rd_data_nb[63:0], 64'h0);
    chk("t2_byp_same", rd_data[63:0], 64'h1234);
    edge_step(); idle();
    chk("t2_nb_after", rd_data_nb[63:0], 64'h1234);

    // 3: write conflict, port 1 wins
    @(negedge clk);
    wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {64'hBB, 64'hAA}; rd_addr = {5'd3, 5'd7};
    #1 chk("t3_byp_conf", rd_data[127:64], 64'hBB);
    chk("t3_nb_old", rd_data_nb[127:64], 64'h0);
    edge_step(); idle();
    chk("t3_stored", rd_data[127:64], 64'hBB);
    chk("t3_nb_stored", rd_data_nb[127:64], 64'hBB);
    chk("t3_port0_r7", rd_data[63:0], 64'h1234);

    // 4: zero register
    @(negedge clk);
    wr_en = 2'b01; wr_addr[4:0] = 5'd0; wr_data[63:0] = '1; rd_addr[4:0] = 5'd0;
    iss_en = 1'b1; iss_rd = 5'd0;
    #1 chk("t4_r0_same", rd_data[63:0], 64'h0);
    edge_step(); idle();
    chk("t4_r0_after", rd_data[63:0], 64'h0);
    chk("t4_r0_nb", rd_data_nb[63:0], 64'h0);
    chk("t4_busy0", 64'(busy_vec[0]), 64'h0);

    // 5: scoreboard set then clear
    @(negedge clk);
    iss_en = 1'b1; iss_rd = 5'd9; rd_addr[4:0] = 5'd9;
    #1 chk("t5_busy_pre", 64'(busy_vec[9]), 64'h0);
    edge_step(); idle();
    chk("t5_busy_set", 64'(busy_vec[9]), 64'h1);
    chk("t5_rdbusy", 64'(rd_busy[0]), 64'h1);
    wr_en = 2'b01; wr_addr[4:0] = 5'd9; wr_data[63:0] = 64'h99;
    #1 chk("t5_rdbusy_mask", 64'(rd_busy[0]), 64'h0);
    chk("t5_nb_rdbusy", 64'(rd_busy_nb[0]), 64'h1);
    chk("t5_byp_data", rd_data[63:0], 64'h99);
    edge_step(); idle();
    chk("t5_busy_clr", 64'(busy_vec[9]), 64'h0);
    chk("t5_rdbusy_clr", 64'(rd_busy[0]), 64'h0);

    // 6: set dominates clear
    @(negedge clk);
    iss_en = 1'b1; iss_rd = 5'd9;
    edge_step(); idle();
    iss_en = 1'b1; iss_rd = 5'd9;
    wr_en = 2'b10; wr_addr[9:5] = 5'd9; wr_data[127:64] = 64'h66;
    edge_step(); idle();
    chk("t6_busy_kept", 64'(busy_vec[9]), 64'h1);
    chk("t6_data", rd_data[63:0], 64'h66);
    chk("t6_nb_data", rd_data_nb[63:0], 64'h66);
    chk("t6_busy_vec", 64'(busy_vec), 64'h200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
